// File: rtl/hcsr04_scan_scheduler.sv
// Round-robin HC-SR04 scan scheduler: one trigger/echo timer shared across
// NUM_SENSORS channels. Optional echo glitch filter: HCSR04_SCAN_GLITCH_FILTER_EN.
module hcsr04_scan_scheduler #(
    parameter int NUM_SENSORS    = 4,
    parameter int TRIG_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 3800000,
    parameter int GUARD_CYCLES   = 6000000,
    parameter int WIDTH_W        = 22,
    localparam int ID_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] sensor_mask,
    input  logic [NUM_SENSORS-1:0] echo,
    output logic [NUM_SENSORS-1:0] trig,
    output logic                   result_valid,
    output logic [ID_W-1:0]        result_id,
    output logic [WIDTH_W-1:0]     result_width,
    output logic                   result_timeout,
    output logic                   busy
);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        GUARD
    } state_t;

    localparam logic [31:0] TRIG_END  = 32'(TRIG_CYCLES - 1);
    localparam logic [31:0] TO_END    = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] GUARD_END = 32'(GUARD_CYCLES - 1);

    state_t                 state;
    state_t                 state_n;
    logic [NUM_SENSORS-1:0] sync1;
    logic [NUM_SENSORS-1:0] sync2;
    logic [ID_W-1:0]        sel;
    logic [ID_W-1:0]        last;
    logic [ID_W-1:0]        pick;
    logic [ID_W-1:0]        hi_idx;
    logic [ID_W-1:0]        lo_idx;
    logic                   hi_found;
    logic [31:0]            cnt;
    logic [WIDTH_W-1:0]     wcnt;
    logic [NUM_SENSORS-1:0] trig_n;
    logic                   echo_raw;
    logic                   echo_s;
    logic                   echo_d;
    logic                   rise;
    logic                   fall;
    logic                   start;
    logic                   to_hit;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= echo;
            sync2 <= sync1;
        end
    end

    assign echo_raw = sync2[sel];

`ifdef HCSR04_SCAN_GLITCH_FILTER_EN
    logic       echo_f;
    logic [1:0] fcnt;

    // New level must persist 4 cycles before it is accepted.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            echo_f <= 1'b0;
            fcnt   <= '0;
        end else if (echo_raw == echo_f) begin
            fcnt <= '0;
        end else if (fcnt == 2'd3) begin
            echo_f <= echo_raw;
            fcnt   <= '0;
        end else begin
            fcnt <= fcnt + 2'd1;
        end
    end

    assign echo_s = echo_f;
`else
    assign echo_s = echo_raw;
`endif

    assign rise   = echo_s & ~echo_d;
    assign fall   = ~echo_s & echo_d;
    assign start  = enable && (sensor_mask != '0);
    assign to_hit = (cnt >= TO_END);
    assign busy   = (state != IDLE);

    // Next channel: lowest masked index above last, else lowest masked.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
            if (sensor_mask[i]) begin
                lo_idx = ID_W'(i);
                if (ID_W'(i) > last) begin
                    hi_idx   = ID_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        pick = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (start) state_n = TRIG;
            TRIG:      if (cnt == TRIG_END) state_n = WAIT_RISE;
            WAIT_RISE: begin
                if (rise)        state_n = MEASURE;
                else if (to_hit) state_n = GUARD;
            end
            MEASURE:   if (fall || to_hit) state_n = GUARD;
            GUARD:     if (cnt == GUARD_END) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        trig_n = '0;
        if (state_n == TRIG) begin
            trig_n = NUM_SENSORS'(1) << ((state == IDLE) ? pick : sel);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            trig           <= '0;
            sel            <= '0;
            last           <= ID_W'(NUM_SENSORS - 1);
            cnt            <= '0;
            wcnt           <= '0;
            echo_d         <= 1'b0;
            result_valid   <= 1'b0;
            result_id      <= '0;
            result_width   <= '0;
            result_timeout <= 1'b0;
        end else begin
            trig         <= trig_n;
            echo_d       <= echo_s;
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sel  <= pick;
                        last <= pick;
                        cnt  <= '0;
                        wcnt <= '0;
                    end
                end
                TRIG: begin
                    cnt <= (cnt == TRIG_END) ? '0 : cnt + 32'd1;
                end
                WAIT_RISE: begin
                    cnt <= cnt + 32'd1;
                    if (rise) begin
                        wcnt <= '0;
                    end else if (to_hit) begin
                        cnt            <= '0;
                        result_valid   <= 1'b1;
                        result_id      <= sel;
                        result_width   <= wcnt;
                        result_timeout <= 1'b1;
                    end
                end
                MEASURE: begin
                    cnt <= cnt + 32'd1;
                    if (echo_s && (wcnt != '1)) wcnt <= wcnt + 1'b1;
                    if (fall || to_hit) begin
                        cnt            <= '0;
                        result_valid   <= 1'b1;
                        result_id      <= sel;
                        result_width   <= wcnt;
                        result_timeout <= ~fall;
                    end
                end
                GUARD: begin
                    cnt <= cnt + 32'd1;
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_hcsr04_scan_scheduler.sv
// Directed bench for hcsr04_scan_scheduler with short trigger/timeout/guard
// parameters and an echo responder that answers each trigger.
module tb_hcsr04_scan_scheduler;

    localparam int N  = 4;
    localparam int TC = 10;
    localparam int TO = 1000;
    localparam int GC = 50;
    localparam int WW = 22;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [N-1:0]  mask = '0;
    logic [N-1:0]  echo = '0;
    logic [N-1:0]  trig;
    logic          rv;
    logic [1:0]    rid;
    logic [WW-1:0] rw;
    logic          rto;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int multi  = 0;
    bit resp_on = 1'b0;
    int resp_delay = 10;
    int resp_len = 100;

    always #5 clk = ~clk;

    hcsr04_scan_scheduler #(
        .NUM_SENSORS   (N),
        .TRIG_CYCLES   (TC),
        .TIMEOUT_CYCLES(TO),
        .GUARD_CYCLES  (GC),
        .WIDTH_W       (WW)
    ) u_dut (
        .ACLK          (clk),
        .ARESETN       (rst_n),
        .enable        (enable),
        .sensor_mask   (mask),
        .echo          (echo),
        .trig          (trig),
        .result_valid  (rv),
        .result_id     (rid),
        .result_width  (rw),
        .result_timeout(rto),
        .busy          (busy)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if ($countones(trig) > 1) multi++;

    // Raise the fired channel's echo resp_delay cycles after trig falls.
    initial begin : responder
        logic [N-1:0] prev;
        int ch;
        prev = '0;
        forever begin
            @(negedge clk);
            if (resp_on && prev != '0 && trig == '0) begin
                ch = 0;
                for (int i = 0; i < N; i++) if (prev[i]) ch = i;
                repeat (resp_delay) @(negedge clk);
                echo[ch] = 1'b1;
                repeat (resp_len) @(negedge clk);
                echo[ch] = 1'b0;
            end
            prev = trig;
        end
    end

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        mask   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_trig(input int ch, input int limit, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < limit) begin
            @(negedge clk);
            n++;
            if (trig[ch]) ok = 1'b1;
        end
    endtask

    task automatic trig_len(output int hi);
        hi = 1;
        while (trig != '0 && hi < 100) begin
            @(negedge clk);
            if (trig != '0) hi++;
        end
    endtask

    task automatic wait_result(input int limit, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < limit) begin
            @(negedge clk);
            n++;
            if (rv) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        bit ok;
        int n;
        int hi;
        int exp_ids [5] = '{0, 1, 3, 0, 1};

        repeat (2) @(negedge clk);
        check("rst_trig", int'(trig), 0);
        check("rst_valid", int'(rv), 0);
        check("rst_id", int'(rid), 0);
        check("rst_width", int'(rw), 0);
        check("rst_timeout", int'(rto), 0);
        check("rst_busy", int'(busy), 0);
        do_reset();

        // single ping on channel 0
        resp_on = 1'b1; resp_delay = 20; resp_len = 300;
        mask = 4'b0001; enable = 1'b1;
        wait_trig(0, 20, ok);
        check("s1_trig_seen", int'(ok), 1);
        check("s1_trig_vec", int'(trig), 1);
        enable = 1'b0;
        trig_len(hi);
        check("s1_trig_len", hi, TC);
        wait_result(2000, ok, n);
        check("s1_strobe", int'(ok), 1);
        check("s1_id", int'(rid), 0);
        check("s1_width_tol", int'(rw >= 299 && rw <= 301), 1);
        check("s1_timeout", int'(rto), 0);
        @(negedge clk);
        check("s1_pulse", int'(rv), 0);
        wait_idle(200, n);
        check("s1_idle", int'(busy), 0);

        // no echo on channel 2
        resp_on = 1'b0;
        mask = 4'b0100; enable = 1'b1;
        wait_trig(2, 20, ok);
        check("s2_trig_seen", int'(ok), 1);
        check("s2_trig_vec", int'(trig), 4);
        enable = 1'b0;
        trig_len(hi);
        wait_result(1500, ok, n);
        check("s2_strobe", int'(ok), 1);
        check("s2_latency", n, TO);
        check("s2_id", int'(rid), 2);
        check("s2_width", int'(rw), 0);
        check("s2_timeout", int'(rto), 1);
        wait_idle(200, n);
        check("s2_guard", n, GC);

        // rotation over mask 1011
        do_reset();
        resp_on = 1'b1; resp_delay = 10; resp_len = 100;
        mask = 4'b1011; enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_result(1000, ok, n);
            check($sformatf("s3_strobe%0d", k), int'(ok), 1);
            check($sformatf("s3_id%0d", k), int'(rid), exp_ids[k]);
            check($sformatf("s3_to%0d", k), int'(rto), 0);
        end
        enable = 1'b0;
        wait_idle(500, n);
        check("s3_idle", int'(busy), 0);

        // echo stuck high before trigger
        resp_on = 1'b0;
        echo[1] = 1'b1;
        mask = 4'b0010;
        @(negedge clk);
        enable = 1'b1;
        wait_result(1500, ok, n);
        enable = 1'b0;
        check("s4_strobe", int'(ok), 1);
        check("s4_id", int'(rid), 1);
        check("s4_timeout", int'(rto), 1);
        check("s4_width", int'(rw), 0);
        echo[1] = 1'b0;
        wait_idle(200, n);

        // enable dropped mid-measure
        resp_on = 1'b1; resp_delay = 5; resp_len = 200;
        mask = 4'b0001; enable = 1'b1;
        wait_trig(0, 20, ok);
        trig_len(hi);
        repeat (60) @(negedge clk);
        check("s5_busy_mid", int'(busy), 1);
        enable = 1'b0;
        wait_result(1000, ok, n);
        check("s5_strobe", int'(ok), 1);
        check("s5_id", int'(rid), 0);
        check("s5_timeout", int'(rto), 0);
        wait_idle(200, n);
        check("s5_idle", int'(busy), 0);
        repeat (30) @(negedge clk);
        check("s5_stay_idle", int'(busy), 0);
        check("s5_no_trig", int'(trig), 0);

        // asynchronous reset in the middle of a trigger pulse
        resp_on = 1'b0;
        enable = 1'b1;
        wait_trig(0, 20, ok);
        check("s6_trig_seen", int'(ok), 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("s6_trig", int'(trig), 0);
        check("s6_busy", int'(busy), 0);
        check("s6_valid", int'(rv), 0);
        check("s6_id", int'(rid), 0);
        check("s6_width", int'(rw), 0);
        check("s6_timeout", int'(rto), 0);
        enable = 1'b0;
        do_reset();

`ifdef HCSR04_SCAN_GLITCH_FILTER_EN
        // short glitch then clean pulse
        mask = 4'b0001; enable = 1'b1;
        wait_trig(0, 20, ok);
        enable = 1'b0;
        trig_len(hi);
        repeat (10) @(negedge clk);
        echo[0] = 1'b1;
        repeat (2) @(negedge clk);
        echo[0] = 1'b0;
        repeat (10) @(negedge clk);
        echo[0] = 1'b1;
        repeat (200) @(negedge clk);
        echo[0] = 1'b0;
        wait_result(1000, ok, n);
        check("s7_strobe", int'(ok), 1);
        check("s7_timeout", int'(rto), 0);
        check("s7_width_tol", int'(rw >= 199 && rw <= 201), 1);
        wait_idle(200, n);
`endif

        check("trig_onehot", multi, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hcsr04_scan_scheduler.md
# hcsr04_scan_scheduler

Round-robin scan controller that shares one measurement engine (trigger generator plus echo-width timer) between up to NUM_SENSORS HC-SR04 ultrasonic sensors. It fires one sensor at a time, measures its echo pulse, enforces an acoustic guard interval against cross-talk, and emits a tagged result per ping. It sits between the sensor pins and the HCSR04 AXI-Lite register block, which captures results and drives enable and mask.

## Interface
- NUM_SENSORS, 4, number of sensor channels (1..16)
- TRIG_CYCLES, 1000, trigger pulse length in ACLK cycles (10 us at 100 MHz)
- TIMEOUT_CYCLES, 3800000, maximum wait from trigger fall to echo fall (38 ms)
- GUARD_CYCLES, 6000000, quiet time after each ping before the next trigger (60 ms)
- WIDTH_W, 22, result width; must satisfy 2^WIDTH_W − 1 ≥ TIMEOUT_CYCLES

- ACLK  in  1  system clock
- ARESETN  in  1  asynchronous active-low reset
- enable  in  1  scanning allowed while high
- sensor_mask  in  NUM_SENSORS  1 = channel included in scan
- echo  in  NUM_SENSORS  raw asynchronous echo inputs
- trig  out  NUM_SENSORS  trigger outputs, at most one high
- result_valid  out  1  one-cycle result strobe
- result_id  out  clog2(NUM_SENSORS) (min 1)  channel of current result
- result_width  out  WIDTH_W  echo high time in ACLK cycles
- result_timeout  out  1  ping ended by timeout
- busy  out  1  high in any state other than IDLE

## Operation
- Each echo bit passes a 2-flop synchronizer; only the selected channel's synchronized echo (echo_s) is used.
- States: IDLE, TRIG, WAIT_RISE, MEASURE, GUARD.
- IDLE: if enable=1 and sensor_mask≠0, select the next channel (see below), clear counters, go to TRIG.
- TRIG: trig[sel]=1 for exactly TRIG_CYCLES cycles, then WAIT_RISE; timeout counter starts at 0.
- WAIT_RISE: wait for a 0→1 edge on echo_s; go to MEASURE with the width counter at 0. An echo already high on entry is not an edge.
- MEASURE: the width counter increments every cycle echo_s=1; on the 1→0 edge go to GUARD with result_valid=1 and result_timeout=0.
- Timeout: the timeout counter runs through WAIT_RISE and MEASURE. On reaching TIMEOUT_CYCLES, go to GUARD with result_valid=1 and result_timeout=1. result_width holds the count so far (0 if no rise).
- GUARD: count GUARD_CYCLES, then go to IDLE. IDLE re-arms on the next cycle if enabled.
- Channel selection: the lowest-index masked channel strictly above the last-served index, wrapping to index 0. After reset the last-served index is NUM_SENSORS−1, so channel 0 is served first if masked. The mask is sampled only at selection.
- Deasserting enable never aborts a ping: the current ping finishes, including GUARD, then the block stays in IDLE.
- Width counter saturates at all-ones; it never wraps.

## Timing
- Reset values: trig=0, result_valid=0, result_id=0, result_width=0, result_timeout=0, busy=0, state IDLE. trig clears asynchronously on ARESETN low, including mid-pulse.
- From IDLE with the selection condition true, trig rises on the next ACLK edge.
- Echo-to-state latency is 2 cycles on both edges, so the measured width equals the raw high time ±1 cycle.
- result_valid rises on the cycle after the echo_s fall is seen or the timeout is reached. It is high for exactly 1 cycle.
- result_id, result_width and result_timeout are registered together with result_valid and hold until the next strobe. There is no backpressure.
- Minimum ping period is TRIG_CYCLES + 2 + GUARD_CYCLES + 1 cycles.

## Configuration
- HCSR04_SCAN_GLITCH_FILTER_EN defined: echo_s changes only after the synchronized input holds a new value for 4 consecutive cycles. Pulses shorter than 4 cycles are ignored, and edge latency becomes 6 cycles on both edges, so the width is unchanged.
- Undefined: no filter; 2-cycle latency as stated above.

## Test plan
Simulation parameters for all scenarios: TRIG_CYCLES=10, TIMEOUT_CYCLES=1000, GUARD_CYCLES=50, NUM_SENSORS=4.
- Single ping, mask=0001, enable=1: echo[0] goes high 20 cycles after trig falls and stays high 300 cycles. Expect trig[0] high for exactly 10 cycles, then one strobe with id=0, width=300±1, timeout=0.
- No echo, mask=0100: expect a strobe with id=2, width=0, timeout=1 exactly 1000 cycles after trig falls, then 50 guard cycles.
- Rotation, mask=1011, all echoes 100 cycles: expect the result id sequence 0,1,3,0,1,… with no two trig bits ever high together.
- Stuck-high echo[1]=1 before the trigger, mask=0010: expect timeout=1 and width=0.
- Enable drop and reset: drop enable mid-MEASURE, and the ping still completes with a strobe, then busy=0 after guard. Pull ARESETN low during TRIG, and trig=0 immediately with all outputs at their reset values.
- With HCSR04_SCAN_GLITCH_FILTER_EN: a 2-cycle echo glitch followed by a clean 200-cycle pulse yields width=200±1.
